// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction-memory loader
// Assembles framed little-endian words from a byte stream and releases the core on a good checksum.
module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        ImWr,
    output logic [31:0] ImAddr,
    output logic [31:0] ImData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error,
    output logic [15:0] WordCount
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE, HDR_LO, HDR_HI, DATA, WRITE, CHK, DONE, ERR
    } stateT;

    stateT       state, nextState;
    logic [15:0] length;
    logic [7:0]  checksum;
    logic [1:0]  byteIdx;

    logic        xfer;
    logic        startLoad;
    logic [31:0] hdrLen;
    logic [15:0] nextCount;

    assign xfer      = RxValid && RxReady;
    assign startLoad = Start && (state == IDLE || state == DONE || state == ERR);
    assign hdrLen    = {16'd0, RxData, length[7:0]};
    assign nextCount = WordCount + 16'd1;
    // WordCount only advances on the edge that ends WRITE, so the address holds through the strobe.
    assign ImAddr    = BASE_ADDR + {14'd0, WordCount, 2'b00};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        RxReady   = 1'b0;
        ImWr      = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        CpuHold   = 1'b1;
        case (state)
            IDLE: begin
                if (Start) nextState = HDR_LO;
            end
            HDR_LO: begin
                RxReady = 1'b1;
                if (xfer) nextState = HDR_HI;
            end
            HDR_HI: begin
                RxReady = 1'b1;
                if (xfer) nextState = (hdrLen == 32'd0 || hdrLen > MAX_WORDS) ? ERR : DATA;
            end
            DATA: begin
                RxReady = 1'b1;
                if (xfer && byteIdx == 2'd3) nextState = WRITE;
            end
            WRITE: begin
                ImWr      = 1'b1;
                nextState = (nextCount == length) ? CHK : DATA;
            end
            CHK: begin
                RxReady = 1'b1;
                if (xfer) nextState = (RxData == checksum) ? DONE : ERR;
            end
            DONE: begin
                Done    = 1'b1;
                CpuHold = 1'b0;
                if (Start) nextState = HDR_LO;
            end
            ERR: begin
                Error = 1'b1;
                if (Start) nextState = HDR_LO;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            length    <= 16'd0;
            checksum  <= 8'd0;
            byteIdx   <= 2'd0;
            ImData    <= 32'd0;
            WordCount <= 16'd0;
        end else if (startLoad) begin
            WordCount <= 16'd0;
            checksum  <= 8'd0;
            byteIdx   <= 2'd0;
        end else begin
            case (state)
                HDR_LO: if (xfer) length[7:0]  <= RxData;
                HDR_HI: if (xfer) length[15:8] <= RxData;
                DATA: begin
                    if (xfer) begin
                        ImData[{byteIdx, 3'b000} +: 8] <= RxData;
                        checksum <= checksum ^ RxData;
                        byteIdx  <= byteIdx + 2'd1;
                    end
                end
                WRITE: WordCount <= nextCount;
                default: ;
            endcase
        end
    end

endmodule
